// File: rtl/dff_behavioral.sv
// WIDTH-bit behavioural D register with a synchronous active-high clear, edge flags and a saturating change counter.
// Define DFF_BEHAVIORAL_SCAN_EN to add a scan chain (scan_en/scan_in/scan_out) that shifts q toward the MSB.
module dff_behavioral #(
    parameter int unsigned      WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    parameter int unsigned      CNT_W     = 8
) (
    input  logic [WIDTH-1:0] d,
    input  logic             clk,
    input  logic             clrn,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             any_chg,
    output logic [CNT_W-1:0] chg_cnt
`ifdef DFF_BEHAVIORAL_SCAN_EN
    ,
    input  logic             scan_en,
    input  logic             scan_in,
    output logic             scan_out
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

`ifdef DFF_BEHAVIORAL_SCAN_EN
    // Appending scan_in below q makes the shifted value the low WIDTH bits and the
    // outgoing MSB the top bit, which also holds for WIDTH == 1.
    logic [WIDTH:0] scan_cat;
    assign scan_cat = {q_q, scan_in};
    assign scan_out = scan_cat[WIDTH];
`endif

    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        q_d    = d;
        rise_d = d & ~q_q;
        fall_d = ~d & q_q;
        cnt_d  = cnt_q;
        if ((d != q_q) && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
`ifdef DFF_BEHAVIORAL_SCAN_EN
        if (scan_en) begin
            q_d    = scan_cat[WIDTH-1:0];
            rise_d = rise_q;
            fall_d = fall_q;
            cnt_d  = cnt_q;
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (clrn) begin
            q_q    <= RESET_VAL;
            rise_q <= '0;
            fall_q <= '0;
            cnt_q  <= '0;
        end else begin
            q_q    <= q_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            cnt_q  <= cnt_d;
        end
    end

    assign q       = q_q;
    assign qn      = ~q_q;
    assign rise    = rise_q;
    assign fall    = fall_q;
    assign any_chg = |(rise_q | fall_q);
    assign chg_cnt = cnt_q;

endmodule

// File: tb/tb_dff_behavioral.sv
// Scoreboard bench for dff_behavioral: a WIDTH=4 instance with nonzero RESET_VAL and a WIDTH=1, CNT_W=2 instance.
// Stimulus pushes hand-computed expectations per edge; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_dff_behavioral;

    typedef struct {
        bit         chk;
        int         id;
        logic [3:0] q;
        logic [3:0] rise;
        logic [3:0] fall;
        logic [7:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    always #2 clk = ~clk;

    logic [3:0] m_d;
    logic       m_clrn;
    logic [3:0] m_q, m_qn, m_rise, m_fall;
    logic       m_any;
    logic [7:0] m_cnt;

    logic       l_d;
    logic       l_clrn;
    logic       l_q, l_qn, l_rise, l_fall, l_any;
    logic [1:0] l_cnt;

    logic       sc_en;
    logic       sc_in;
`ifdef DFF_BEHAVIORAL_SCAN_EN
    logic       m_so, l_so;
`endif

    exp_t sb_m[$];
    exp_t sb_l[$];
    int   n_checks = 0;
    int   n_errors = 0;

    dff_behavioral #(.WIDTH(4), .RESET_VAL(4'b0101), .CNT_W(8)) u_main (
        .d(m_d), .clk(clk), .clrn(m_clrn), .q(m_q), .qn(m_qn),
        .rise(m_rise), .fall(m_fall), .any_chg(m_any), .chg_cnt(m_cnt)
`ifdef DFF_BEHAVIORAL_SCAN_EN
        , .scan_en(sc_en), .scan_in(sc_in), .scan_out(m_so)
`endif
    );

    dff_behavioral #(.WIDTH(1), .CNT_W(2)) u_leg (
        .d(l_d), .clk(clk), .clrn(l_clrn), .q(l_q), .qn(l_qn),
        .rise(l_rise), .fall(l_fall), .any_chg(l_any), .chg_cnt(l_cnt)
`ifdef DFF_BEHAVIORAL_SCAN_EN
        , .scan_en(1'b0), .scan_in(1'b0), .scan_out(l_so)
`endif
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input bit chk, input int id, input logic [3:0] q,
                                input logic [3:0] r, input logic [3:0] f, input logic [7:0] cnt);
        exp_t e;
        e.chk = chk; e.id = id; e.q = q; e.rise = r; e.fall = f; e.cnt = cnt;
        return e;
    endfunction

    // Inputs change 1 ns after a negedge; with glitch set, leg inputs flip again 1 ns after the posedge
    // and are restored before the next edge, so only the edge-time values may matter.
    task automatic step(input logic mc, input logic [3:0] md, input exp_t me,
                        input logic lc, input logic ld, input exp_t le,
                        input bit glitch, input logic sen, input logic sin);
        @(negedge clk);
        #1;
        m_clrn = mc; m_d = md; l_clrn = lc; l_d = ld; sc_en = sen; sc_in = sin;
        sb_m.push_back(me);
        sb_l.push_back(le);
        if (glitch) begin
            #2;
            l_clrn = ~lc;
            l_d    = ~ld;
        end
    endtask

    // Monitor
    initial begin
        exp_t em, el;
        forever begin
            @(negedge clk);
            if (sb_m.size() > 0) begin
                em = sb_m.pop_front();
                if (em.chk) begin
                    check($sformatf("main%0d.q", em.id),    {4'b0, m_q},    {4'b0, em.q});
                    check($sformatf("main%0d.qn", em.id),   {4'b0, m_qn},   {4'b0, ~em.q});
                    check($sformatf("main%0d.rise", em.id), {4'b0, m_rise}, {4'b0, em.rise});
                    check($sformatf("main%0d.fall", em.id), {4'b0, m_fall}, {4'b0, em.fall});
                    check($sformatf("main%0d.any", em.id),  {7'b0, m_any},  {7'b0, |(em.rise | em.fall)});
                    check($sformatf("main%0d.cnt", em.id),  m_cnt,          em.cnt);
`ifdef DFF_BEHAVIORAL_SCAN_EN
                    check($sformatf("main%0d.scan_out", em.id), {7'b0, m_so}, {7'b0, em.q[3]});
`endif
                end
            end
            if (sb_l.size() > 0) begin
                el = sb_l.pop_front();
                if (el.chk) begin
                    check($sformatf("leg%0d.q", el.id),    {7'b0, l_q},    {7'b0, el.q[0]});
                    check($sformatf("leg%0d.qn", el.id),   {7'b0, l_qn},   {7'b0, ~el.q[0]});
                    check($sformatf("leg%0d.rise", el.id), {7'b0, l_rise}, {7'b0, el.rise[0]});
                    check($sformatf("leg%0d.fall", el.id), {7'b0, l_fall}, {7'b0, el.fall[0]});
                    check($sformatf("leg%0d.any", el.id),  {7'b0, l_any},  {7'b0, el.rise[0] | el.fall[0]});
                    check($sformatf("leg%0d.cnt", el.id),  {6'b0, l_cnt},  {6'b0, el.cnt[1:0]});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Stimulus: (main clr, main d, main expected, leg clr, leg d, leg expected, glitch, scan_en, scan_in)
    initial begin
        m_clrn = 1'b1; m_d = 4'h0; l_clrn = 1'b1; l_d = 1'b0; sc_en = 1'b0; sc_in = 1'b0;

        // Clear with d=1: both report reset state
        step(1, 4'hF,    mk(1, 1, 4'b0101, 4'h0,    4'h0,    8'd0), 1, 1, mk(1, 1, 4'h0, 4'h0, 4'h0, 8'd0), 0, 0, 0);
        // Capture after clear: flags against RESET_VAL
        step(0, 4'b0110, mk(1, 2, 4'b0110, 4'b0010, 4'b0001, 8'd1), 0, 1, mk(1, 2, 4'h1, 4'h1, 4'h0, 8'd1), 0, 0, 0);
        step(0, 4'b0110, mk(1, 3, 4'b0110, 4'h0,    4'h0,    8'd1), 0, 1, mk(1, 3, 4'h1, 4'h0, 4'h0, 8'd1), 0, 0, 0);
        step(0, 4'b1001, mk(1, 4, 4'b1001, 4'b1001, 4'b0110, 8'd2), 0, 0, mk(1, 4, 4'h0, 4'h0, 4'h1, 8'd2), 0, 0, 0);
        // Clear mid-activity discards the pending change
        step(1, 4'b0000, mk(1, 5, 4'b0101, 4'h0,    4'h0,    8'd0), 0, 1, mk(1, 5, 4'h1, 4'h1, 4'h0, 8'd3), 0, 0, 0);
        step(0, 4'b0101, mk(1, 6, 4'b0101, 4'h0,    4'h0,    8'd0), 0, 0, mk(1, 6, 4'h0, 4'h0, 4'h1, 8'd3), 0, 0, 0);
        // Leg CNT_W=2 saturation: clear then alternate for 5 edges -> 1,2,3,3,3
        step(0, 4'b0000, mk(1, 7, 4'b0000, 4'h0,    4'b0101, 8'd1), 1, 1, mk(1, 7, 4'h0, 4'h0, 4'h0, 8'd0), 0, 0, 0);
        step(0, 4'b1111, mk(1, 8, 4'b1111, 4'b1111, 4'h0,    8'd2), 0, 1, mk(1, 8, 4'h1, 4'h1, 4'h0, 8'd1), 0, 0, 0);
        step(0, 4'b1111, mk(1, 9, 4'b1111, 4'h0,    4'h0,    8'd2), 0, 0, mk(1, 9, 4'h0, 4'h0, 4'h1, 8'd2), 0, 0, 0);
        step(0, 4'b0000, mk(1,10, 4'b0000, 4'h0,    4'b1111, 8'd3), 0, 1, mk(1,10, 4'h1, 4'h1, 4'h0, 8'd3), 0, 0, 0);
        step(0, 4'b0000, mk(1,11, 4'b0000, 4'h0,    4'h0,    8'd3), 0, 0, mk(1,11, 4'h0, 4'h0, 4'h1, 8'd3), 0, 0, 0);
        step(0, 4'b0011, mk(1,12, 4'b0011, 4'b0011, 4'h0,    8'd4), 0, 1, mk(1,12, 4'h1, 4'h1, 4'h0, 8'd3), 0, 0, 0);
        // Leg: d and clrn toggle between edges; only edge-time values count
        step(0, 4'b0011, mk(1,13, 4'b0011, 4'h0,    4'h0,    8'd4), 1, 1, mk(1,13, 4'h0, 4'h0, 4'h0, 8'd0), 1, 0, 0);
        step(0, 4'b0011, mk(1,14, 4'b0011, 4'h0,    4'h0,    8'd4), 0, 1, mk(1,14, 4'h1, 4'h1, 4'h0, 8'd1), 1, 0, 0);
        step(0, 4'b0011, mk(1,15, 4'b0011, 4'h0,    4'h0,    8'd4), 1, 0, mk(1,15, 4'h0, 4'h0, 4'h0, 8'd0), 1, 0, 0);
        step(0, 4'b0011, mk(1,16, 4'b0011, 4'h0,    4'h0,    8'd4), 0, 1, mk(1,16, 4'h1, 4'h1, 4'h0, 8'd1), 1, 0, 0);
        step(0, 4'b0011, mk(1,17, 4'b0011, 4'h0,    4'h0,    8'd4), 0, 1, mk(1,17, 4'h1, 4'h0, 4'h0, 8'd1), 1, 0, 0);
        step(0, 4'b0011, mk(1,18, 4'b0011, 4'h0,    4'h0,    8'd4), 0, 1, mk(1,18, 4'h1, 4'h0, 4'h0, 8'd1), 0, 0, 0);
`ifdef DFF_BEHAVIORAL_SCAN_EN
        // Scan shift toward MSB from q=0; flags and count hold; clear wins over scan
        step(0, 4'b0000, mk(1,19, 4'b0000, 4'h0, 4'b0011, 8'd5), 0, 1, mk(1,19, 4'h1, 4'h0, 4'h0, 8'd1), 0, 0, 0);
        step(0, 4'b1110, mk(1,20, 4'b0001, 4'h0, 4'b0011, 8'd5), 0, 1, mk(1,20, 4'h1, 4'h0, 4'h0, 8'd1), 0, 1, 1);
        step(0, 4'b1110, mk(1,21, 4'b0011, 4'h0, 4'b0011, 8'd5), 0, 1, mk(1,21, 4'h1, 4'h0, 4'h0, 8'd1), 0, 1, 1);
        step(0, 4'b1110, mk(1,22, 4'b0111, 4'h0, 4'b0011, 8'd5), 0, 1, mk(1,22, 4'h1, 4'h0, 4'h0, 8'd1), 0, 1, 1);
        step(0, 4'b1110, mk(1,23, 4'b1111, 4'h0, 4'b0011, 8'd5), 0, 1, mk(1,23, 4'h1, 4'h0, 4'h0, 8'd1), 0, 1, 1);
        step(1, 4'b1110, mk(1,24, 4'b0101, 4'h0, 4'h0,    8'd0), 0, 1, mk(1,24, 4'h1, 4'h0, 4'h0, 8'd1), 0, 1, 1);
`endif

        for (int i = 0; i < 8 && (sb_m.size() > 0 || sb_l.size() > 0); i++) begin
            @(negedge clk);
        end
        #1;
        check("drain", 8'(sb_m.size() + sb_l.size()), 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
